// File: rtl/gpio_ctrl_apb_pkg.sv
// Shared types and constants for the GPIO controller APB requester.
package gpio_ctrl_apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  // FSM encoding kept as plain constants so legacy tools can read it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // Read data returned to the requester: only clean reads carry data.
  function automatic logic [APB_DATA_W-1:0] mask_rdata(
    input logic                  is_write,
    input logic                  err,
    input logic [APB_DATA_W-1:0] rdata
  );
    return (is_write || err) ? {APB_DATA_W{1'b0}} : rdata;
  endfunction

endpackage

// File: rtl/gpio_ctrl_apb_initiator.sv
// APB4 requester: converts a valid/ready command into one SETUP/ACCESS
// transfer toward a decoded CSR slave and returns a valid/ready response.
module gpio_ctrl_apb_initiator
  import gpio_ctrl_apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_W         = 12,
  parameter int SEL_LSB        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  input  logic [APB_STRB_W-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_W-1:0]     paddr,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_STRB_W-1:0] pstrb,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [SEL_W:0] NUM_SLAVES_W = (SEL_W + 1)'(NUM_SLAVES);

  state_t                  state_q,       state_d;
  logic [ADDR_W-1:0]       paddr_q,       paddr_d;
  logic [NUM_SLAVES-1:0]   psel_q,        psel_d;
  logic                    penable_q,     penable_d;
  logic                    pwrite_q,      pwrite_d;
  logic [APB_DATA_W-1:0]   pwdata_q,      pwdata_d;
  logic [APB_STRB_W-1:0]   pstrb_q,       pstrb_d;
  logic [CNT_W-1:0]        cnt_q,         cnt_d;
  logic                    rsp_valid_q,   rsp_valid_d;
  logic [APB_DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                    rsp_err_q,     rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic [SEL_W-1:0] sel_idx_s;
  logic             dec_err_s;
  logic             accept_s;
  logic             timeout_hit_s;

  // cmd_ready is IDLE-only and forced low while reset is held.
  assign cmd_ready     = (state_q == ST_IDLE) && !rst;
  assign sel_idx_s     = cmd_addr[SEL_LSB +: SEL_W];
  assign dec_err_s     = ({1'b0, sel_idx_s} >= NUM_SLAVES_W);
  assign accept_s      = cmd_valid && cmd_ready;
  assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !pready;

  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  // Next-state logic: FSM sequencing, slave decode, wait-state timeout.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && dec_err_s) begin
          // Unmapped slave: answer immediately, never touch the bus.
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = {APB_DATA_W{1'b0}};
        end else if (accept_s) begin
          state_d  = ST_SETUP;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : {APB_DATA_W{1'b0}};
          pstrb_d  = cmd_write ? cmd_strb  : {APB_STRB_W{1'b0}};
          for (int i = 0; i < NUM_SLAVES; i++) begin
            psel_d[i] = (sel_idx_s == SEL_W'(i));
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = {CNT_W{1'b0}};
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d       = ST_RESP;
          psel_d        = {NUM_SLAVES{1'b0}};
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = mask_rdata(pwrite_q, pslverr, prdata);
        end else if (timeout_hit_s) begin
          state_d       = ST_RESP;
          psel_d        = {NUM_SLAVES{1'b0}};
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = {APB_DATA_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = {APB_DATA_W{1'b0}};
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        psel_d      = {NUM_SLAVES{1'b0}};
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset drops any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      paddr_q       <= {ADDR_W{1'b0}};
      psel_q        <= {NUM_SLAVES{1'b0}};
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= {APB_DATA_W{1'b0}};
      pstrb_q       <= {APB_STRB_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {APB_DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule
